// File: rtl/alu_flags_unit.sv
// Architectural O/S/C/Z flag register with a REQ/ACK branch-condition evaluator
// and a small LIFO of saved flag values for interrupt/call entry and exit.
module alu_flags_unit #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       O_IN,
    input  logic       S_IN,
    input  logic       C_IN,
    input  logic       Z_IN,
    input  logic       WE_FLAGS,
    output logic [3:0] FLAGS,
    input  logic [3:0] COND,
    input  logic       COND_REQ,
    output logic       COND_ACK,
    output logic       COND_TRUE,
    input  logic       PUSH,
    input  logic       POP,
    output logic       STACK_FULL,
    output logic       STACK_EMPTY,
    output logic       STACK_ERR,
    output logic [1:0] COND_STATE
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    // Handshake: COND_REQ is a level held by the requester until it sees COND_ACK,
    // and must be dropped in that cycle. COND_ACK is a one-cycle strobe, and
    // COND_TRUE keeps its value until the next strobe.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } cond_state_e;

    cond_state_e state_q, state_d;
    logic [3:0]  cond_q, cond_d;
    logic        ack_q, ack_d;
    logic        true_q, true_d;

    logic [3:0]       flags_q, flags_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, pop_ptr;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic             push_ok, pop_ok, stack_fault;
    logic [3:0]       mem_q [STACK_DEPTH];

    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic o, s, cy, z, lt, r;
        o  = f[3];
        s  = f[2];
        cy = f[1];
        z  = f[0];
        lt = s ^ o;
        r  = 1'b0;
        case (c)
            4'd0:  r = 1'b1;
            4'd1:  r = z;
            4'd2:  r = ~z;
            4'd3:  r = s;
            4'd4:  r = ~s;
            4'd5:  r = cy;
            4'd6:  r = ~cy;
            4'd7:  r = o;
            4'd8:  r = ~o;
            4'd9:  r = lt;
            4'd10: r = ~lt;
            4'd11: r = ~z & ~lt;
            4'd12: r = z | lt;
            4'd13: r = cy & ~z;
            4'd14: r = ~cy | z;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        ack_d   = 1'b0;
        true_d  = true_q;
        case (state_q)
            ST_IDLE: begin
                if (COND_REQ) begin
                    cond_d  = COND;
                    state_d = ST_EVAL;
                end
            end
            // flags_q already includes any write made at the edge that entered EVAL
            ST_EVAL: begin
                true_d  = eval_cond(cond_q, flags_q);
                ack_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cond_q  <= 4'd0;
            ack_q   <= 1'b0;
            true_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            ack_q   <= ack_d;
            true_q  <= true_d;
        end
    end

    // A rejected stack operation leaves the stack alone but still lets WE_FLAGS through.
    always_comb begin
        push_ok     = PUSH & ~POP & ~full_q;
        pop_ok      = POP & ~PUSH & ~empty_q;
        stack_fault = (PUSH & POP) | (PUSH & full_q) | (POP & empty_q);
        pop_ptr     = ptr_q - PTR_W'(1);
        flags_d     = flags_q;
        ptr_d       = ptr_q;
        err_d       = err_q | stack_fault;
        if (pop_ok) begin
            flags_d = mem_q[pop_ptr[IDX_W-1:0]];
            ptr_d   = pop_ptr;
        end else if (WE_FLAGS) begin
            flags_d = {O_IN, S_IN, C_IN, Z_IN};
        end
        if (push_ok) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
        full_d  = (ptr_d == PTR_W'(STACK_DEPTH));
        empty_d = (ptr_d == '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q <= 4'd0;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[ptr_q[IDX_W-1:0]] <= flags_q;
        end
    end

    assign FLAGS       = flags_q;
    assign COND_ACK    = ack_q;
    assign COND_TRUE   = true_q;
    assign STACK_FULL  = full_q;
    assign STACK_EMPTY = empty_q;
    assign STACK_ERR   = err_q;
    assign COND_STATE  = state_q;

endmodule
